// File: rtl/match_sequencer.sv
// match_sequencer: runs one two-player match around the game controller.
// It detects the start button, holds the ball before each serve, freezes
// play after a point, keeps both scores, handles pause and declares the
// winner. Every output is registered.
//
// Optional build macro: WIN_BY_TWO_EN. When it is defined, a player must
// reach WIN_SCORE and lead by two. A score of 31 ends the game regardless
// of lead.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   frame_tick_i  one-cycle pulse per video frame
//   start_i       start button level (acts on its rising edge)
//   pause_i       one-cycle pause toggle pulse
//   point_p1_i    one-cycle pulse: player 1 scored
//   point_p2_i    one-cycle pulse: player 2 scored
//   ball_en_o     ball motion enable (high only in PLAY)
//   ball_reset_o  one-cycle recentre pulse
//   serve_dir_o   0 = serve toward p1, 1 = serve toward p2
//   score1_o      player 1 score
//   score2_o      player 2 score
//   state_o       state encoding (IDLE=0 .. OVER=5)
//   winner_o      00 none, 01 p1, 10 p2
//   game_over_o   high while in OVER
module match_sequencer #(
    parameter logic [4:0] WIN_SCORE   = 5'd11,
    parameter logic [7:0] SERVE_DELAY = 8'd60,
    parameter logic [7:0] POINT_DELAY = 8'd90
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       point_p1_i,
    input  logic       point_p2_i,
    output logic       ball_en_o,
    output logic       ball_reset_o,
    output logic       serve_dir_o,
    output logic [4:0] score1_o,
    output logic [4:0] score2_o,
    output logic [2:0] state_o,
    output logic [1:0] winner_o,
    output logic       game_over_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_PAUSED = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [4:0]  score1_q, score1_d, score2_q, score2_d;
    logic [1:0]  winner_q, winner_d;
    logic        serve_dir_q, serve_dir_d;
    logic        ball_reset_q, ball_reset_d;
    logic        ball_en_q, ball_en_d;
    logic        game_over_q, game_over_d;
    logic        start_q;

    logic        start_rise;
    logic [4:0]  s1_inc, s2_inc;
    logic        p1_wins, p2_wins;

    assign start_rise = start_i & ~start_q;
    assign s1_inc     = score1_q + 5'd1;
    assign s2_inc     = score2_q + 5'd1;

    // Win test on the scorer's incremented score. Scores cannot pass 31:
    // the game ends at WIN_SCORE, or at the hard cap of 31 in win-by-two mode.
    always_comb begin
`ifdef WIN_BY_TWO_EN
        p1_wins = (s1_inc == 5'd31) ||
                  ((s1_inc >= WIN_SCORE) && ({1'b0, s1_inc} >= ({1'b0, score2_q} + 6'd2)));
        p2_wins = (s2_inc == 5'd31) ||
                  ((s2_inc >= WIN_SCORE) && ({1'b0, s2_inc} >= ({1'b0, score1_q} + 6'd2)));
`else
        p1_wins = (s1_inc == WIN_SCORE);
        p2_wins = (s2_inc == WIN_SCORE);
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            timer_q      <= 8'd0;
            score1_q     <= 5'd0;
            score2_q     <= 5'd0;
            winner_q     <= 2'b00;
            serve_dir_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            ball_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            // Resets high: a button held through reset does not start a match.
            start_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_reset_q <= ball_reset_d;
            ball_en_q    <= ball_en_d;
            game_over_q  <= game_over_d;
            start_q      <= start_i;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        winner_d     = winner_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d      = S_SERVE;
                    timer_d      = SERVE_DELAY;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                // A count of 0 or 1 expires on the next tick, so the hold
                // lasts max(SERVE_DELAY,1) ticks.
                if (frame_tick_i) begin
                    if (timer_q <= 8'd1) begin
                        state_d = S_PLAY;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // p1 outranks p2, and any point outranks pause. The player
                // who conceded receives the serve.
                if (point_p1_i) begin
                    score1_d    = s1_inc;
                    serve_dir_d = 1'b1;
                    if (p1_wins) begin
                        state_d  = S_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = S_POINT;
                        timer_d = POINT_DELAY;
                    end
                end else if (point_p2_i) begin
                    score2_d    = s2_inc;
                    serve_dir_d = 1'b0;
                    if (p2_wins) begin
                        state_d  = S_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = S_POINT;
                        timer_d = POINT_DELAY;
                    end
                end else if (pause_i) begin
                    state_d = S_PAUSED;
                end
            end
            S_POINT: begin
                if (frame_tick_i) begin
                    if (timer_q <= 8'd1) begin
                        state_d      = S_SERVE;
                        timer_d      = SERVE_DELAY;
                        ball_reset_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (pause_i) state_d = S_PLAY;
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d      = S_SERVE;
                    timer_d      = SERVE_DELAY;
                    score1_d     = 5'd0;
                    score2_d     = 5'd0;
                    winner_d     = 2'b00;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    // Output logic: decoded from the next state so that the registered
    // flags line up with state_q.
    always_comb begin
        ball_en_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    assign ball_en_o    = ball_en_q;
    assign ball_reset_o = ball_reset_q;
    assign serve_dir_o  = serve_dir_q;
    assign score1_o     = score1_q;
    assign score2_o     = score2_q;
    assign state_o      = state_q;
    assign winner_o     = winner_q;
    assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer (WIN_SCORE=3, SERVE_DELAY=2,
// POINT_DELAY=4). The stimulus pushes a hand-computed output snapshot after
// each clock. A monitor pops each snapshot on the falling edge and compares it.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0;
    logic       point_p1 = 1'b0, point_p2 = 1'b0;
    logic       ball_en, ball_reset, serve_dir, game_over;
    logic [4:0] score1, score2;
    logic [2:0] state;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];

    match_sequencer #(.WIN_SCORE(5'd3), .SERVE_DELAY(8'd2), .POINT_DELAY(8'd4)) dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .start_i(start),
        .pause_i(pause), .point_p1_i(point_p1), .point_p2_i(point_p2),
        .ball_en_o(ball_en), .ball_reset_o(ball_reset), .serve_dir_o(serve_dir),
        .score1_o(score1), .score2_o(score2), .state_o(state),
        .winner_o(winner), .game_over_o(game_over)
    );

    always #5 clk = ~clk;

    // Snapshot layout: state, score1, score2, winner, serve_dir, ball_en, ball_reset, game_over
    function automatic logic [18:0] mk(input logic [2:0] st, input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [1:0] w, input logic dir, input logic en,
                                       input logic br, input logic go);
        return {st, s1, s2, w, dir, en, br, go};
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [18:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {state, score1, score2, winner, serve_dir, ball_en, ball_reset, game_over};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%0d s1=%0d s2=%0d w=%b dir=%b en=%b br=%b go=%b, want st=%0d s1=%0d s2=%0d w=%b dir=%b en=%b br=%b go=%b",
                         n, a[18:16], a[15:11], a[10:6], a[5:4], a[3], a[2], a[1], a[0],
                         e[18:16], e[15:11], e[10:6], e[5:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic step(input logic ft, input logic pa, input logic p1, input logic p2,
                        input string nm, input logic [18:0] e);
        frame_tick = ft; pause = pa; point_p1 = p1; point_p2 = p2;
        @(posedge clk);
        #1;
        frame_tick = 1'b0; pause = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // POINT countdown (4 ticks) followed by the serve hold (2 ticks).
    task automatic recover(input logic [4:0] s1, input logic [4:0] s2, input logic dir);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "point_hold", mk(3, s1, s2, 0, dir, 0, 0, 0));
        step(1, 0, 0, 0, "point_expire", mk(1, s1, s2, 0, dir, 0, 1, 0));
        step(1, 0, 0, 0, "serve_hold",   mk(1, s1, s2, 0, dir, 0, 0, 0));
        step(1, 0, 0, 0, "serve_go",     mk(2, s1, s2, 0, dir, 1, 0, 0));
    endtask

    logic [4:0] fs2;

    initial begin
        // Reset with the start button held: must not start a match.
        rst = 1'b1; start = 1'b1;
        step(0, 0, 0, 0, "reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, "reset2", mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(0, 0, 0, 0, "held_start", mk(0, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b0;
        step(0, 0, 0, 0, "idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        step(0, 0, 0, 0, "start", mk(1, 0, 0, 0, 0, 0, 1, 0));
        step(0, 0, 0, 0, "br_one_cycle", mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, "serve_tick1", mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, "serve_tick2", mk(2, 0, 0, 0, 0, 1, 0, 0));

        step(0, 0, 1, 0, "p1_point", mk(3, 1, 0, 0, 1, 0, 0, 0));
        recover(1, 0, 1);
        step(0, 0, 1, 1, "p1_p2_same", mk(3, 2, 0, 0, 1, 0, 0, 0));
        recover(2, 0, 1);

        step(0, 1, 0, 0, "pause", mk(4, 2, 0, 0, 1, 0, 0, 0));
        step(0, 0, 1, 0, "paused_p1", mk(4, 2, 0, 0, 1, 0, 0, 0));
        start = 1'b0;
        step(0, 0, 0, 0, "paused_idle", mk(4, 2, 0, 0, 1, 0, 0, 0));
        start = 1'b1;
        step(0, 0, 0, 1, "paused_start_p2", mk(4, 2, 0, 0, 1, 0, 0, 0));
        step(0, 1, 0, 0, "resume", mk(2, 2, 0, 0, 1, 1, 0, 0));
        step(0, 1, 0, 1, "p2_beats_pause", mk(3, 2, 1, 0, 0, 0, 0, 0));
        recover(2, 1, 0);
        step(0, 0, 0, 1, "p2_point2", mk(3, 2, 2, 0, 0, 0, 0, 0));
        recover(2, 2, 0);
`ifdef WIN_BY_TWO_EN
        step(0, 0, 0, 1, "p2_lead_one", mk(3, 2, 3, 0, 0, 0, 0, 0));
        recover(2, 3, 0);
        step(0, 0, 0, 1, "p2_wins_by_two", mk(5, 2, 4, 2'b10, 0, 0, 0, 1));
        fs2 = 5'd4;
`else
        step(0, 0, 0, 1, "p2_wins", mk(5, 2, 3, 2'b10, 0, 0, 0, 1));
        fs2 = 5'd3;
`endif
        step(0, 0, 1, 0, "over_p1", mk(5, 2, fs2, 2'b10, 0, 0, 0, 1));
        step(0, 1, 0, 0, "over_pause", mk(5, 2, fs2, 2'b10, 0, 0, 0, 1));
        start = 1'b0;
        step(0, 0, 0, 0, "over_hold", mk(5, 2, fs2, 2'b10, 0, 0, 0, 1));
        // Restart with a coincident frame tick: that tick must not count.
        start = 1'b1;
        step(1, 0, 0, 0, "restart", mk(1, 0, 0, 0, 0, 0, 1, 0));
        step(1, 0, 0, 0, "entry_tick", mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0, "replay", mk(2, 0, 0, 0, 0, 1, 0, 0));

        step(0, 0, 1, 0, "p1_again", mk(3, 1, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, "pt_t1", mk(3, 1, 0, 0, 1, 0, 0, 0));
        step(1, 0, 0, 0, "pt_t2", mk(3, 1, 0, 0, 1, 0, 0, 0));
        rst = 1'b1;
        step(1, 0, 0, 0, "mid_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        step(0, 0, 0, 0, "post_reset", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Drain the scoreboard with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
